// File: rtl/poly_mac_scheduler_pkg.sv
// Shared types and constants for the two-channel Horner polynomial evaluator.
// Q-format positions and the default Taylor coefficients live here.
package poly_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int FRAC_X   = 14;
  localparam int FRAC_Y   = 25;
  localparam int PROD_LSB = 14;

  // Coefficients of exp(x) truncated after x^5, in Q7.25
  localparam logic [31:0] COEF_A0 = 32'h0200_0000;
  localparam logic [31:0] COEF_A1 = 32'h0200_0000;
  localparam logic [31:0] COEF_A2 = 32'h0100_0000;
  localparam logic [31:0] COEF_A3 = 32'h0055_5555;
  localparam logic [31:0] COEF_A4 = 32'h0015_5555;
  localparam logic [31:0] COEF_A5 = 32'h0004_4444;

endpackage

// File: rtl/poly_mac_scheduler_if.sv
// Bundle of the two request channels and the result channel.
// slave is the scheduler side, master is the requester/consumer side.
interface poly_mac_scheduler_if #(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32
);
  logic                i_valid0;
  logic                o_ready0;
  logic [WIDTHIN-1:0]  i_x0;
  logic                i_valid1;
  logic                o_ready1;
  logic [WIDTHIN-1:0]  i_x1;
  logic                o_valid;
  logic                i_ready;
  logic [WIDTHOUT-1:0] o_y;
  logic                o_ch;

  modport slave (
    input  i_valid0, i_x0, i_valid1, i_x1, i_ready,
    output o_ready0, o_ready1, o_valid, o_y, o_ch
  );

  modport master (
    output i_valid0, i_x0, i_valid1, i_x1, i_ready,
    input  o_ready0, o_ready1, o_valid, o_y, o_ch
  );
endinterface

// File: rtl/poly_mac_scheduler_mac.sv
// Combinational multiply-add: y = ((a * b) >> 14) + c, unsigned, wrapping.
// The slice re-aligns the Q2.14 operand so the product stays in Q7.25.
module poly_mac
  import poly_pkg::*;
#(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32
) (
  input  logic [WIDTHOUT-1:0] a,
  input  logic [WIDTHIN-1:0]  b,
  input  logic [WIDTHOUT-1:0] c,
  output logic [WIDTHOUT-1:0] y
);
  logic [WIDTHOUT+WIDTHIN-1:0] prod;

  assign prod = a * b;
  assign y    = prod[PROD_LSB +: WIDTHOUT] + c;
endmodule

// File: rtl/poly_mac_scheduler.sv
// Round-robin scheduler sharing one MAC between two Horner evaluations of a
// 5th-order polynomial; results carry the channel tag of their requester.
module poly_mac_scheduler
  import poly_pkg::*;
#(
  parameter int                WIDTHIN  = 16,
  parameter int                WIDTHOUT = 32,
  parameter logic [WIDTHOUT-1:0] A0 = COEF_A0,
  parameter logic [WIDTHOUT-1:0] A1 = COEF_A1,
  parameter logic [WIDTHOUT-1:0] A2 = COEF_A2,
  parameter logic [WIDTHOUT-1:0] A3 = COEF_A3,
  parameter logic [WIDTHOUT-1:0] A4 = COEF_A4,
  parameter logic [WIDTHOUT-1:0] A5 = COEF_A5
) (
  input  logic                 clk,
  input  logic                 reset,
  poly_mac_scheduler_if.slave  bus,
  output logic                 o_busy
);
  state_t              state, state_nx;
  logic [2:0]          step, step_nx;
  logic [WIDTHOUT-1:0] acc, acc_nx, y_r, y_nx;
  logic [WIDTHOUT-1:0] mac_a, mac_c, mac_y, coef;
  logic [WIDTHIN-1:0]  x_r, x_nx, mac_b, grant_x;
  logic                ch_r, ch_nx, last_grant, lg_nx;
  logic                valid_r, valid_nx, och_r, och_nx;
  logic                grant_ch, accept;

  // A tie goes to the channel that was not served last
  assign grant_ch     = (bus.i_valid0 && bus.i_valid1) ? ~last_grant : bus.i_valid1;
  assign grant_x      = grant_ch ? bus.i_x1 : bus.i_x0;
  assign bus.o_ready0 = (state == IDLE) && bus.i_valid0 && !grant_ch;
  assign bus.o_ready1 = (state == IDLE) && bus.i_valid1 && grant_ch;
  assign accept       = bus.o_ready0 || bus.o_ready1;

  assign bus.o_valid = valid_r;
  assign bus.o_y     = y_r;
  assign bus.o_ch    = och_r;
  assign o_busy      = (state != IDLE);

  always_comb begin
    coef = '0;
    case (step)
      3'd1:    coef = A3;
      3'd2:    coef = A2;
      3'd3:    coef = A1;
      3'd4:    coef = A0;
      default: coef = '0;
    endcase
  end

  poly_mac #(.WIDTHIN(WIDTHIN), .WIDTHOUT(WIDTHOUT)) u_mac (
    .a (mac_a),
    .b (mac_b),
    .c (mac_c),
    .y (mac_y)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_nx = state;
    step_nx  = step;
    acc_nx   = acc;
    x_nx     = x_r;
    ch_nx    = ch_r;
    lg_nx    = last_grant;
    valid_nx = valid_r;
    y_nx     = y_r;
    och_nx   = och_r;
    mac_a    = acc;
    mac_b    = x_r;
    mac_c    = coef;

    unique case (state)
      IDLE: begin
        // The first Horner step runs on the incoming operand during the handshake
        mac_a = A5;
        mac_b = grant_x;
        mac_c = A4;
        if (accept) begin
          x_nx     = grant_x;
          ch_nx    = grant_ch;
          lg_nx    = grant_ch;
          acc_nx   = mac_y;
          step_nx  = 3'd1;
          state_nx = CALC;
        end
      end
      CALC: begin
        acc_nx  = mac_y;
        step_nx = step + 3'd1;
        if (step == 3'd4) begin
          y_nx     = mac_y;
          och_nx   = ch_r;
          valid_nx = 1'b1;
          step_nx  = 3'd0;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (bus.i_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step       <= '0;
      acc        <= '0;
      x_r        <= '0;
      ch_r       <= 1'b0;
      last_grant <= 1'b1;
      valid_r    <= 1'b0;
      y_r        <= '0;
      och_r      <= 1'b0;
    end else begin
      state      <= state_nx;
      step       <= step_nx;
      acc        <= acc_nx;
      x_r        <= x_nx;
      ch_r       <= ch_nx;
      last_grant <= lg_nx;
      valid_r    <= valid_nx;
      y_r        <= y_nx;
      och_r      <= och_nx;
    end
  end
endmodule

// File: doc/poly_mac_scheduler.md
Name: poly_mac_scheduler

Overview:
Round-robin scheduler that shares one combinational multiply-add datapath between two independent polynomial-evaluation requesters. It evaluates the 5th-order Taylor polynomial by Horner's rule, one MAC step per cycle, tagging each result with its source channel. It sits between two upstream x producers and a single downstream consumer. It uses valid/ready handshakes on all three sides.

Parameters:
WIDTHIN, 16, input x width, unsigned Q2.14
WIDTHOUT, 32, coefficient/accumulator/result width, Q7.25
A0, 32'h0200_0000, constant term (1.0)
A1, 32'h0200_0000, x coefficient (1.0)
A2, 32'h0100_0000, x^2 coefficient (0.5)
A3, 32'h0055_5555, x^3 coefficient (1/6)
A4, 32'h0015_5555, x^4 coefficient (1/24)
A5, 32'h0004_4444, x^5 coefficient (1/120)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
i_valid0  in  1  channel 0 request valid
o_ready0  out  1  channel 0 request accepted this cycle when high with i_valid0
i_x0  in  WIDTHIN  channel 0 operand
i_valid1  in  1  channel 1 request valid
o_ready1  out  1  channel 1 request accepted this cycle when high with i_valid1
i_x1  in  WIDTHIN  channel 1 operand
o_valid  out  1  result valid
i_ready  in  1  downstream ready
o_y  out  WIDTHOUT  result, Q7.25
o_ch  out  1  channel that produced o_y
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, step=0, acc=0, x_r=0, last_grant=1 (channel 0 wins the first tie), o_valid=0, o_y=0, o_ch=0. Reset mid-computation discards the job; no result is emitted.
- States: IDLE -> CALC -> HOLD -> IDLE.
- IDLE:
  - o_readyN is combinational. Ready goes to the granted channel only, and only in IDLE.
  - If exactly one channel is valid, grant it. If both are valid, grant !last_grant.
  - On handshake: latch x_r=i_xN, ch_r=N, last_grant=N, acc=A5*x+A4 via MAC, step=1, go to CALC.
- CALC:
  - MAC operands: a=acc, b=x_r, c=coef[step].
  - coef[1]=A3, coef[2]=A2, coef[3]=A1, coef[4]=A0.
  - Each cycle acc<=mac, step++.
  - At step 4: o_y<=mac, o_ch<=ch_r, o_valid<=1, go to HOLD.
- HOLD:
  - o_valid, o_y and o_ch are stable until i_ready.
  - On o_valid&&i_ready: o_valid<=0, go to IDLE.
  - i_ready is ignored in other states.
- Timing: handshake at edge T gives o_valid high from edge T+4. Minimum spacing between accepts is 6 cycles (one mandatory IDLE bubble).
- Both o_ready0 and o_ready1 are low outside IDLE. Requesters must hold i_valid and i_x until accepted.
- MAC arithmetic, all unsigned:
  - prod = a(32b) * b(16b), 48 bits.
  - sum = prod[45:14] + c, truncated to 32 bits.
  - No saturation; overflow wraps.
- Fairness: under continuous requests from both channels, grants alternate 0,1,0,1. A lone requester is granted every opportunity.
- Channel switching on i_validN while not granted has no effect. No request is lost or duplicated.

Decomposition:
- Shared package poly_pkg:
  - state encoding IDLE/CALC/HOLD (2-bit)
  - Q-format constants FRAC_X=14, FRAC_Y=25, PROD_LSB=14
  - default coefficient constants A0..A5
- One sub-module, poly_mac: purely combinational a*b, slice [45:14], add c. It is instantiated once.
- Scheduler, step counter and coefficient mux live in poly_mac_scheduler.

Test Plan:
- Ch0 only, i_x0=0x0000, i_ready=1 -> o_valid 4 cycles after accept, o_y=0x0200_0000, o_ch=0.
- Ch1 only, i_x1=0x4000 (1.0), i_ready=1 -> o_y=0x056E_EEEE (sum of coefficients), o_ch=1.
- Both valid continuously with x0=0x4000, x1=0x0000 -> results alternate ch0,ch1,ch0; values 0x056E_EEEE/0x0200_0000. Accept spacing is 6 cycles.
- Backpressure: i_ready=0 for 10 cycles after o_valid -> o_y/o_ch held, o_ready0/1 low throughout. Release returns to IDLE next cycle.
- Assert reset during CALC step 2 -> o_valid never rises. Outputs are 0 and state is IDLE. A subsequent ch1 request is granted; its result matches the bit-exact model (random x, 1000 vectors).
- Simultaneous first requests after reset -> ch0 granted first, ch1 next.
